uart_rx_data_loader: RTL and testbench

//  UART receiver and word assembler that preloads the data memory over a serial link.
//  It is the receive-side counterpart of the MEM-stage UART transmit path (tx_o).

---
 rtl/uart_rx_data_loader.sv | 166 ++++++++++++++++
 tb/tb_uart_rx_data_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_data_loader.sv
// UART 8N1 receiver that assembles little-endian bytes into 32-bit words
// and writes them to consecutive data-memory addresses until WORDS are loaded.
module uart_rx_data_loader #(
  parameter int CLK_PER_BIT  = 434,
  parameter int ADDR_W       = 5,
  parameter int WORDS        = 32,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              rx_i,
  output logic              en_addr_data_o,
  output logic [ADDR_W-1:0] addr_data_o,
  output logic [31:0]       data_data_o,
  output logic              frame_err_o,
  output logic              load_done_o,
  output logic              busy_o
);

  localparam int unsigned HALF      = CLK_PER_BIT / 2;
  localparam int unsigned CNT_W     = $clog2(CLK_PER_BIT);
  localparam int unsigned TMO_LIMIT = TIMEOUT_BITS * CLK_PER_BIT;
  localparam int unsigned TMO_W     = $clog2(TMO_LIMIT + 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t            state_q, state_d;
  logic              rx_meta_q, rx_s_q, rx_prev_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [31:0]       word_q, word_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] addr_out_q, addr_out_d;
  logic [31:0]       data_out_q, data_out_d;
  logic              strobe_q, strobe_d;
  logic              ferr_q, ferr_d;
  logic              done_q, done_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic start_det, bit_tick, tmo_fire;

  assign start_det = (state_q == S_IDLE) && rx_prev_q && !rx_s_q;
  assign bit_tick  = (cnt_q == CNT_W'(CLK_PER_BIT - 1));
  assign tmo_fire  = (state_q == S_IDLE) && (byte_cnt_q != '0) &&
                     (tmo_q == TMO_W'(TMO_LIMIT - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    word_d     = word_q;
    byte_cnt_d = byte_cnt_q;
    addr_d     = addr_q;
    addr_out_d = addr_out_q;
    data_out_d = data_out_q;
    strobe_d   = 1'b0;
    ferr_d     = 1'b0;
    done_d     = done_q | (strobe_q && (addr_out_q == LAST_ADDR));

    // Timeout drops the partial word even when a start edge arrives in the same cycle.
    if ((state_q == S_IDLE) && (byte_cnt_q != '0)) tmo_d = tmo_q + 1'b1;
    else                                            tmo_d = '0;
    if (tmo_fire) begin
      byte_cnt_d = '0;
      tmo_d      = '0;
    end
    if (start_det) tmo_d = '0;

    unique case (state_q)
      S_IDLE: begin
        if (start_det) begin
          state_d = S_START;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      S_START: begin
        // Counter keeps running so data samples land at whole bit times from start detect.
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(HALF - 1)) state_d = rx_s_q ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (bit_tick) begin
          cnt_d   = '0;
          shift_d = {rx_s_q, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (bit_tick) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (rx_s_q) begin
            word_d[{byte_cnt_q, 3'b000} +: 8] = shift_q;
            byte_cnt_d = byte_cnt_q + 2'd1;
            if ((byte_cnt_q == 2'd3) && !done_q) begin
              strobe_d   = 1'b1;
              addr_out_d = addr_q;
              data_out_d = {shift_q, word_q[23:0]};
              addr_d     = addr_q + 1'b1;
            end
          end else begin
            ferr_d     = 1'b1;
            byte_cnt_d = '0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= S_IDLE;
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      rx_prev_q  <= 1'b1;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      word_q     <= '0;
      byte_cnt_q <= '0;
      addr_q     <= '0;
      addr_out_q <= '0;
      data_out_q <= '0;
      strobe_q   <= 1'b0;
      ferr_q     <= 1'b0;
      done_q     <= 1'b0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= rx_i;
      rx_s_q     <= rx_meta_q;
      rx_prev_q  <= rx_s_q;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      word_q     <= word_d;
      byte_cnt_q <= byte_cnt_d;
      addr_q     <= addr_d;
      addr_out_q <= addr_out_d;
      data_out_q <= data_out_d;
      strobe_q   <= strobe_d;
      ferr_q     <= ferr_d;
      done_q     <= done_d;
      tmo_q      <= tmo_d;
    end
  end

  assign en_addr_data_o = strobe_q;
  assign addr_data_o    = addr_out_q;
  assign data_data_o    = data_out_q;
  assign frame_err_o    = ferr_q;
  assign load_done_o    = done_q;
  assign busy_o         = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_data_loader.sv
// Bench for uart_rx_data_loader: byte vectors from a table, strobes checked
// against a scoreboard queue, plus hand sequences for abort, timeout and reset.
module tb_uart_rx_data_loader;

  localparam int CPB  = 16;
  localparam int AW   = 5;
  localparam int NW   = 4;
  localparam int TMOB = 20;
  localparam int CP   = 10;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          rx_i    = 1'b1;
  logic          en_addr_data_o;
  logic [AW-1:0] addr_data_o;
  logic [31:0]   data_data_o;
  logic          frame_err_o;
  logic          load_done_o;
  logic          busy_o;

  uart_rx_data_loader #(
    .CLK_PER_BIT (CPB),
    .ADDR_W      (AW),
    .WORDS       (NW),
    .TIMEOUT_BITS(TMOB)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .rx_i          (rx_i),
    .en_addr_data_o(en_addr_data_o),
    .addr_data_o   (addr_data_o),
    .data_data_o   (data_data_o),
    .frame_err_o   (frame_err_o),
    .load_done_o   (load_done_o),
    .busy_o        (busy_o)
  );

  always #(CP/2) sys_clk = ~sys_clk;

  typedef struct {
    logic          rst_before;
    logic [7:0]    b;
    logic          stop;
    logic          exp_strobe;
    logic [AW-1:0] exp_addr;
    logic [31:0]   exp_data;
    logic          exp_ferr;
    logic          exp_done;
  } vec_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   ferr_cnt = 0;
  time  strobe_t = 0;
  time  byte_t   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every strobe must match the oldest expected write.
  always @(negedge sys_clk) begin
    if (frame_err_o === 1'b1) ferr_cnt++;
    if (en_addr_data_o === 1'b1) begin
      strobe_t = $time;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_strobe: got addr %0d data %h, expected no strobe",
                 addr_data_o, data_data_o);
      end else begin
        mon_e = sb_q.pop_front();
        if (addr_data_o !== mon_e.addr || data_data_o !== mon_e.data) begin
          n_fail++;
          $display("FAIL strobe_payload: got addr %0d data %h, expected addr %0d data %h",
                   addr_data_o, data_data_o, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    @(negedge sys_clk);
    rx_i   = 1'b0;
    byte_t = $time;
    repeat (CPB) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (CPB) @(negedge sys_clk);
    end
    rx_i = stop;
    repeat (CPB) @(negedge sys_clk);
    rx_i = 1'b1;
    repeat (4) @(negedge sys_clk);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    rx_i    = 1'b1;
    repeat (3) @(negedge sys_clk);
    check("reset_ctrl_outputs", {26'd0, en_addr_data_o, frame_err_o, load_done_o, busy_o,
                                 2'b00}, 32'd0);
    check("reset_addr", {{(32-AW){1'b0}}, addr_data_o}, 32'd0);
    check("reset_data", data_data_o, 32'd0);
    sb_q.delete();
    sys_rst = 1'b0;
    repeat (4) @(negedge sys_clk);
  endtask

  function automatic vec_t mk(logic rst, logic [7:0] b, logic stop, logic s,
                              logic [AW-1:0] a, logic [31:0] d, logic fe, logic dn);
    vec_t v;
    v.rst_before = rst;  v.b = b;  v.stop = stop;  v.exp_strobe = s;
    v.exp_addr = a;  v.exp_data = d;  v.exp_ferr = fe;  v.exp_done = dn;
    return v;
  endfunction

  initial begin
    #(200000 * CP);
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[$];
    vec_t v;
    int   f0;
    int   k;
    logic [7:0] wb;

    // 1: single word DEADBEEF
    vt.push_back(mk(1, 8'hEF, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 8'hBE, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 8'hAD, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 8'hDE, 1, 1, 0, 32'hDEADBEEF, 0, 0));
    // 3: framing error drops the partial word
    vt.push_back(mk(1, 8'h01, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 8'h02, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 8'h5A, 0, 0, 0, 0, 1, 0));
    vt.push_back(mk(0, 8'h01, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 8'h02, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 8'h03, 1, 0, 0, 0, 0, 0));
    vt.push_back(mk(0, 8'h04, 1, 1, 0, 32'h04030201, 0, 0));
    // 5: five words, the fifth arrives after load_done
    for (int w = 0; w < 5; w++) begin
      for (int j = 0; j < 4; j++) begin
        wb = 8'(16 * (w + 1) + j);
        vt.push_back(mk((w == 0 && j == 0), wb, 1, (j == 3 && w < NW), AW'(w),
                        {8'(16*(w+1)+3), 8'(16*(w+1)+2), 8'(16*(w+1)+1), 8'(16*(w+1))},
                        0, (w >= NW) || (w == NW-1 && j == 3)));
      end
    end

    do_reset();

    foreach (vt[i]) begin
      v = vt[i];
      if (v.rst_before) do_reset();
      if (v.exp_strobe) sb_q.push_back('{addr: v.exp_addr, data: v.exp_data});
      f0 = ferr_cnt;
      send_byte(v.b, v.stop);
      check($sformatf("vec%0d_ferr", i), 32'(ferr_cnt - f0), {31'd0, v.exp_ferr});
      check($sformatf("vec%0d_done", i), {31'd0, load_done_o}, {31'd0, v.exp_done});
      check($sformatf("vec%0d_busy", i), {31'd0, busy_o}, 32'd0);
      if (v.exp_strobe) begin
        check($sformatf("vec%0d_strobe_seen", i), sb_q.size(), 32'd0);
        check($sformatf("vec%0d_strobe_latency", i), 32'(strobe_t - byte_t), 32'(147 * CP));
      end
    end

    // 2: short low pulse aborts in START
    do_reset();
    f0 = ferr_cnt;
    @(negedge sys_clk);
    rx_i = 1'b0;
    repeat (4) @(negedge sys_clk);
    check("glitch_busy_set", {31'd0, busy_o}, 32'd1);
    rx_i = 1'b1;
    k = 0;
    while (busy_o !== 1'b0 && k < 10) begin
      @(negedge sys_clk);
      k++;
    end
    check("glitch_busy_clear", {31'd0, busy_o}, 32'd0);
    repeat (20) @(negedge sys_clk);
    check("glitch_no_ferr", 32'(ferr_cnt - f0), 32'd0);

    // 4: idle timeout drops AA,BB; then a short gap keeps the partial word
    do_reset();
    send_byte(8'hAA, 1);
    send_byte(8'hBB, 1);
    repeat (330) @(negedge sys_clk);
    sb_q.push_back('{addr: AW'(0), data: 32'h11223344});
    send_byte(8'h44, 1);
    send_byte(8'h33, 1);
    send_byte(8'h22, 1);
    send_byte(8'h11, 1);
    check("timeout_word", sb_q.size(), 32'd0);
    sb_q.push_back('{addr: AW'(1), data: 32'hDDCCBBAA});
    send_byte(8'hAA, 1);
    send_byte(8'hBB, 1);
    repeat (100) @(negedge sys_clk);
    send_byte(8'hCC, 1);
    send_byte(8'hDD, 1);
    check("no_timeout_word", sb_q.size(), 32'd0);

    // 6: reset in the middle of the second byte's data bits
    do_reset();
    send_byte(8'h55, 1);
    @(negedge sys_clk);
    rx_i = 1'b0;
    repeat (CPB) @(negedge sys_clk);
    rx_i = 1'b1;
    repeat (3 * CPB) @(negedge sys_clk);
    check("midframe_busy", {31'd0, busy_o}, 32'd1);
    do_reset();
    f0 = ferr_cnt;
    sb_q.push_back('{addr: AW'(0), data: 32'h04030201});
    send_byte(8'h01, 1);
    send_byte(8'h02, 1);
    send_byte(8'h03, 1);
    send_byte(8'h04, 1);
    check("post_reset_word", sb_q.size(), 32'd0);
    check("post_reset_no_ferr", 32'(ferr_cnt - f0), 32'd0);

    repeat (10) @(negedge sys_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
